sop_table_sweeper: RTL
======================

// Module: sop_table_sweeper
// PURPOSE
//  Parametrised successor to the fixed 4-input sum-of-products block: it holds any N-input
//  boolean function as a 2^N-bit truth table. On start it sweeps every input vector, one per
//  clock, and emits the function output, a ones (minterm) count and a mismatch check against an
//  expected table. Used as an on-chip self-checking evaluator for the team's logic exercises.
// PARAMETERS
//  N_IN    4        number of function inputs; table depth = 2**N_IN
//  T_W     2**N_IN  truth-table width (derived, do not override)
//  C_W     N_IN+1   counter width, holds 0..2**N_IN (derived)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  load        in   1      capture table_in/exp_in (IDLE only)
//  table_in    in   T_W    function table; bit i = f(vector i), vector MSB = first input
//  exp_in      in   T_W    expected table for compare
//  start       in   1      begin sweep (IDLE only)
//  hold        in   1      freeze sweep while high
//  busy        out  1      high in RUN
//  out_valid   out  1      vec/r valid this cycle
//  vec         out  N_IN   current input vector
//  r           out  1      table[vec]
//  done        out  1      one-cycle pulse after the last vector
//  ones_cnt    out  C_W    number of vectors with r=1 in the last sweep
//  mis_cnt     out  C_W    number of vectors where table != exp
//  first_mis   out  N_IN   lowest mismatching vector; valid when mis_cnt != 0
// BEHAVIOUR
//  - Reset: state IDLE; table/exp regs, idx, all outputs = 0. Reset mid-RUN aborts the sweep;
//    no done pulse; counts cleared.
//  - FSM IDLE -> RUN on start; RUN -> DONE after vector 2**N_IN-1 is emitted; DONE -> IDLE next cycle.
//  - IDLE: load=1 registers table_in/exp_in. start=1 clears idx/ones_cnt/mis_cnt/first_mis and
//    enters RUN. With load and start in the same cycle, the sweep uses the newly loaded tables.
//  - RUN: each non-hold cycle out_valid=1, vec=idx, r=table[idx]; idx increments on the clock
//    edge; ones_cnt += r; if table[idx]!=exp[idx], mis_cnt += 1, and first_mis=idx on the first
//    mismatch only.
//  - hold=1 in RUN: out_valid=0, idx and counts frozen, vec holds its value. No vector is
//    skipped or repeated.
//  - Latency: start sampled at edge k -> vec 0 valid in cycle k+1; with no hold, done is high
//    in cycle k+1+2**N_IN. busy is high for exactly the valid plus hold cycles.
//  - done: high for one cycle (DONE state). ones_cnt/mis_cnt/first_mis hold their values until
//    the next start or rst.
//  - load or start while in RUN/DONE: ignored (tables and sweep unaffected).
//  - idx wraps to 0 only through a new start. C_W bits prevent overflow at an all-ones table.
//  - All outputs are registered; there is no combinational input-to-output path.
// TESTING
//  1 rst=1 for 2 cycles -> busy=out_valid=done=0, ones_cnt=mis_cnt=first_mis=0.
//  2 N_IN=4; load table=exp=16'h1894; start -> 16 valid cycles; r=1 exactly at vec 2,4,7,11,12;
//    done 17 cycles after start; ones_cnt=5, mis_cnt=0.
//  3 table=16'h1894, exp=16'h1895 -> mis_cnt=1, first_mis=0; exp=16'h0894 -> mis_cnt=1, first_mis=12.
//  4 hold=1 for 3 cycles while vec=5 -> out_valid=0 during hold, vec 5 emitted once, vec 6
//    follows; done at cycle 20; ones_cnt=5.
//  5 table=16'hFFFF, exp=0 -> ones_cnt=16, mis_cnt=16 (5-bit, no wrap), first_mis=0.
//  6 rst during vec 9 -> IDLE next cycle, no done; load 16'h0001 during RUN ignored; fresh
//    start after reset sweeps cleanly with ones_cnt=5 on the 16'h1894 table reloaded after reset.

Source files
------------

// File: rtl/sop_table_sweeper_if.sv
// Bus between the truth-table sweeper and whatever drives it: table load, sweep control,
// per-vector output stream and end-of-sweep statistics.
interface sop_table_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int T_W = 2 ** N_IN;
    localparam int C_W = N_IN + 1;

    logic           load;
    logic [T_W-1:0] table_in;
    logic [T_W-1:0] exp_in;
    logic           start;
    logic           hold;
    logic           busy;
    logic           out_valid;
    logic [N_IN-1:0] vec;
    logic           r;
    logic           done;
    logic [C_W-1:0] ones_cnt;
    logic [C_W-1:0] mis_cnt;
    logic [N_IN-1:0] first_mis;

    modport master (
        output load, table_in, exp_in, start, hold,
        input  busy, out_valid, vec, r, done, ones_cnt, mis_cnt, first_mis
    );

    modport slave (
        input  load, table_in, exp_in, start, hold,
        output busy, out_valid, vec, r, done, ones_cnt, mis_cnt, first_mis
    );
endinterface

// File: rtl/sop_table_sweeper.sv
// Sweeps every input vector of an N-input truth table, one per clock, emitting f(vec) and
// accumulating minterm and mismatch statistics against an expected table.
module sop_table_sweeper #(
    parameter int N_IN = 4
) (
    input  logic                clk,
    input  logic                rst,
    sop_table_sweeper_if.slave  bus
);
    localparam int T_W = 2 ** N_IN;
    localparam int C_W = N_IN + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [T_W-1:0]   tbl_q, exp_q;
    logic [T_W-1:0]   tbl_eff, exp_eff;
    logic [C_W-1:0]   idx;
    logic             last;
    logic             emit;
    logic [N_IN-1:0]  cur_vec;
    logic             cur_r, cur_mis;
    logic [C_W-1:0]   base_ones, base_mis;
    logic [N_IN-1:0]  base_first;

    logic             out_valid_q, r_q;
    logic [N_IN-1:0]  vec_q, first_q;
    logic [C_W-1:0]   ones_q, mis_q;

    // idx is the next vector to emit; reaching 2**N_IN means the table is exhausted
    assign last = (idx == C_W'(T_W));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = RUN;
                emit      = 1'b1;
            end
            RUN: if (!bus.hold) begin
                if (last) state_nxt = DONE;
                else      emit      = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector 0 is emitted on the start edge itself, using tables loaded on that same edge
    always_comb begin
        tbl_eff    = (state == IDLE && bus.load) ? bus.table_in : tbl_q;
        exp_eff    = (state == IDLE && bus.load) ? bus.exp_in   : exp_q;
        cur_vec    = (state == IDLE) ? '0 : idx[N_IN-1:0];
        cur_r      = tbl_eff[cur_vec];
        cur_mis    = tbl_eff[cur_vec] ^ exp_eff[cur_vec];
        base_ones  = (state == IDLE) ? '0 : ones_q;
        base_mis   = (state == IDLE) ? '0 : mis_q;
        base_first = (state == IDLE) ? '0 : first_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q       <= '0;
            exp_q       <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            vec_q       <= '0;
            r_q         <= 1'b0;
            ones_q      <= '0;
            mis_q       <= '0;
            first_q     <= '0;
        end else begin
            if (state == IDLE && bus.load) begin
                tbl_q <= bus.table_in;
                exp_q <= bus.exp_in;
            end
            out_valid_q <= emit;
            if (emit) begin
                vec_q  <= cur_vec;
                r_q    <= cur_r;
                idx    <= C_W'(cur_vec) + C_W'(1);
                ones_q <= base_ones + C_W'(cur_r);
                mis_q  <= base_mis + C_W'(cur_mis);
                if (cur_mis && base_mis == '0) first_q <= cur_vec;
                else                           first_q <= base_first;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.vec       = vec_q;
    assign bus.r         = r_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.mis_cnt   = mis_q;
    assign bus.first_mis = first_q;
endmodule
